// File: rtl/corsel_pkg.sv
// Shared types and helpers for the correction-select unit.
package corsel_pkg;

  localparam int COR_CNT_W = 16;

  typedef enum logic [1:0] {
    ANY    = 2'd0,
    ALL    = 2'd1,
    NEG    = 2'd2,
    BYPASS = 2'd3
  } cor_mode_e;

  // (M - C) mod M for 0 <= C < M; C == 0 must give 0 rather than M.
  function automatic logic [31:0] neg_mod(input logic [31:0] c, input logic [31:0] m);
    if (c == 32'd0) return 32'd0;
    return m - c;
  endfunction

endpackage

// File: rtl/corsel_pipe_reg.sv
// One enabled pipeline stage carrying {valid, value, correction}.
module corsel_pipe_reg #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_value,
  input  logic [DATA_WIDTH-1:0] in_cor,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic [DATA_WIDTH-1:0] out_cor
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_cor   <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_value <= in_value;
      out_cor   <= in_cor;
    end
  end

endmodule

// File: rtl/corsel_np.sv
// Correction-select unit: carries an RNS digit alongside a registered correction
// constant chosen from the sign/flag bus, with a stallable pipeline and a saturating counter.
module corsel_np
  import corsel_pkg::*;
#(
  parameter int          DATA_WIDTH    = 18,
  parameter int          SIGN_W        = 2,
  parameter int          DEPTH         = 2,
  parameter int unsigned DIGIT_CORRECT = 0,
  parameter int unsigned MODULUS       = 2**DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [SIGN_W-1:0]     sign_in,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] A_out,
  output logic [DATA_WIDTH-1:0] cor_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  count_clr,
  output logic [COR_CNT_W-1:0]  cor_count
);

  localparam logic [DATA_WIDTH-1:0] COR_POS = DATA_WIDTH'(DIGIT_CORRECT);
  localparam logic [DATA_WIDTH-1:0] COR_NEG =
    DATA_WIDTH'(neg_mod(32'(DIGIT_CORRECT), 32'(MODULUS)));

  logic advance;

  logic                  s1_valid_reg;
  logic [DATA_WIDTH-1:0] s1_value_reg;
  logic [SIGN_W-1:0]     s1_sign_reg;
  cor_mode_e             s1_mode_reg;
  logic [DATA_WIDTH-1:0] cor_next;

  logic                  stg_valid [1:DEPTH];
  logic [DATA_WIDTH-1:0] stg_value [1:DEPTH];
  logic [DATA_WIDTH-1:0] stg_cor   [1:DEPTH];

  logic [COR_CNT_W-1:0]  count_reg;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Bubbles load zero data so idle slots never show stale operands downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_value_reg <= '0;
      s1_sign_reg  <= '0;
      s1_mode_reg  <= ANY;
    end else if (advance) begin
      s1_valid_reg <= in_valid;
      s1_value_reg <= in_valid ? A : '0;
      s1_sign_reg  <= in_valid ? sign_in : '0;
      s1_mode_reg  <= cor_mode_e'(mode);
    end
  end

  always_comb begin
    cor_next = '0;
    case (s1_mode_reg)
      ANY:     if (|s1_sign_reg) cor_next = COR_POS;
      ALL:     if (&s1_sign_reg) cor_next = COR_POS;
      NEG:     if (|s1_sign_reg) cor_next = COR_NEG;
      default: cor_next = '0;
    endcase
  end

  assign stg_valid[1] = s1_valid_reg;
  assign stg_value[1] = s1_value_reg;
  assign stg_cor[1]   = cor_next;

  for (genvar gi = 2; gi <= DEPTH; gi++) begin : g_stage
    corsel_pipe_reg #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .en       (advance),
      .in_valid (stg_valid[gi-1]),
      .in_value (stg_value[gi-1]),
      .in_cor   (stg_cor[gi-1]),
      .out_valid(stg_valid[gi]),
      .out_value(stg_value[gi]),
      .out_cor  (stg_cor[gi])
    );
  end

  assign out_valid  = stg_valid[DEPTH];
  assign A_out      = stg_value[DEPTH];
  assign cor_result = stg_cor[DEPTH];

  // Clear wins over a coincident transfer.
  always_ff @(posedge clk) begin
    if (reset || count_clr) begin
      count_reg <= '0;
    end else if (out_valid && out_ready && (cor_result != '0) && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign cor_count = count_reg;

endmodule
